// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder; the master issues operands, the slave returns the sum.
interface serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             done;

    modport master (
        output start, A, B, Cin,
        input  ready, S, Cout, Ovf, done
    );

    modport slave (
        input  start, A, B, Cin,
        output ready, S, Cout, Ovf, done
    );
endinterface

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder built from full-adder cells; purely combinational.
// c_msb exposes the carry into the top bit so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout  = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial S = A + B + Cin, LSD first; result in WIDTH/DIGIT cycles, done pulses one cycle later.
// No backpressure: start is taken only while ready (IDLE/DONE) and ignored during RUN.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    serial_adder_if.slave  bus
);
    localparam int             N    = num_digits(WIDTH, DIGIT);
    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] w_s_shift;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic             w_cmsb;
    logic             w_accept;
    logic             w_last;

    assign w_accept = bus.start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == LAST);

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .sum   (w_dsum),
        .cout  (w_dcout),
        .c_msb (w_cmsb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = bus.start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // New digit enters at the MSB end so the sum is aligned after N shifts.
    always_comb begin
        w_s_shift = r_s >> DIGIT;
        w_s_shift[WIDTH-1 -: DIGIT] = w_dsum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.Cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_s     <= w_s_shift;
            r_carry <= w_dcout;
            if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_dcout;
                r_ovf  <= w_cmsb ^ w_dcout;
            end
        end
    end

    assign bus.ready = (r_state != RUN);
    assign bus.done  = (r_state == DONE);
    assign bus.S     = r_s;
    assign bus.Cout  = r_cout;
    assign bus.Ovf   = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder in three configurations against an arithmetic model.
module tb_serial_adder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    serial_adder_if #(.WIDTH(8)) if8  ();
    serial_adder_if #(.WIDTH(4)) if41 ();
    serial_adder_if #(.WIDTH(4)) if44 ();

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8  (.clk(clk), .reset(reset), .bus(if8));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut41 (.clk(clk), .reset(reset), .bus(if41));
    serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut44 (.clk(clk), .reset(reset), .bus(if44));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] ref_sum(input int w, input int a, input int b, input int cin);
        int full, sa, sb, tot, half;
        logic [9:0] r;
        half = 1 << (w - 1);
        full = a + b + cin;
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        tot  = sa + sb + cin;
        r[7:0] = 8'(full % (2 * half));
        r[8]   = (full >= 2 * half);
        r[9]   = (tot > half - 1) || (tot < -half);
        return r;
    endfunction

    function automatic int n_of(input int inst);
        return (inst == 2) ? 1 : 4;
    endfunction

    function automatic int w_of(input int inst);
        return (inst == 0) ? 8 : 4;
    endfunction

    task automatic drive(input int inst, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        case (inst)
            0: begin if8.start = st;  if8.A = a;        if8.B = b;        if8.Cin = cin;  end
            1: begin if41.start = st; if41.A = a[3:0];  if41.B = b[3:0];  if41.Cin = cin; end
            default: begin if44.start = st; if44.A = a[3:0]; if44.B = b[3:0]; if44.Cin = cin; end
        endcase
    endtask

    function automatic logic dut_done(input int inst);
        case (inst)
            0:       return if8.done;
            1:       return if41.done;
            default: return if44.done;
        endcase
    endfunction

    function automatic logic dut_ready(input int inst);
        case (inst)
            0:       return if8.ready;
            1:       return if41.ready;
            default: return if44.ready;
        endcase
    endfunction

    function automatic logic [9:0] dut_res(input int inst);
        case (inst)
            0:       return {if8.Ovf, if8.Cout, if8.S};
            1:       return {if41.Ovf, if41.Cout, 4'h0, if41.S};
            default: return {if44.Ovf, if44.Cout, 4'h0, if44.S};
        endcase
    endfunction

    // One complete operation; returns the result, cycles from acceptance to done, and ready-high count in RUN.
    task automatic do_op(input int inst, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [9:0] res, output int lat, output int busy_rdy);
        @(negedge clk);
        drive(inst, 1'b1, a, b, cin);
        @(negedge clk);
        drive(inst, 1'b0, 8'h00, 8'h00, 1'b0);
        lat = 1;
        busy_rdy = 0;
        while (!dut_done(inst) && lat < 40) begin
            if (dut_ready(inst)) busy_rdy++;
            @(negedge clk);
            lat++;
        end
        res = dut_res(inst);
    endtask

    task automatic op_check(input string tag, input int inst, input logic [7:0] a, input logic [7:0] b,
                            input logic cin);
        logic [9:0] res;
        int lat, busy;
        do_op(inst, a, b, cin, res, lat, busy);
        chk($sformatf("%s_res", tag), 32'(res), 32'(ref_sum(w_of(inst), int'(a), int'(b), int'(cin))));
        chk($sformatf("%s_lat", tag), lat, n_of(inst) + 1);
        chk($sformatf("%s_busy", tag), busy, 0);
    endtask

    initial begin
        logic [9:0] res;
        int lat, busy, k;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
        #1 reset = 1'b1;
        #2;
        chk("rst_S", 32'(if8.S), 0);
        chk("rst_flags", {if8.Cout, if8.Ovf, if8.done, if8.ready}, 4'b0001);
        @(negedge clk);
        reset = 1'b0;

        op_check("add_0F_01", 0, 8'h0F, 8'h01, 1'b0);
        chk("add_0F_01_S", 32'(if8.S), 32'h10);
        op_check("add_FF_01", 0, 8'hFF, 8'h01, 1'b0);
        chk("add_FF_01_cout", 32'(if8.Cout), 1);
        op_check("add_7F_00_1", 0, 8'h7F, 8'h00, 1'b1);
        chk("add_7F_ovf", {if8.Ovf, if8.S}, 9'h180);

        // Asynchronous reset between edges clears the result immediately.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_S", 32'(if8.S), 0);
        chk("arst_flags", {if8.Cout, if8.Ovf, if8.done, if8.ready}, 4'b0001);
        @(negedge clk);
        reset = 1'b0;

        // Stray start during RUN must not disturb the operands.
        @(negedge clk);
        drive(0, 1'b1, 8'h22, 8'h11, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 8'h01, 8'h01, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        k = 2;
        while (!if8.done && k < 40) begin @(negedge clk); k++; end
        chk("ignore_lat", k, 5);
        chk("ignore_S", 32'(if8.S), 32'h33);

        // Start held high: accepted in each DONE cycle, period N+1.
        drive(0, 1'b1, 8'hAA, 8'h55, 1'b0);
        for (int r = 0; r < 2; r++) begin
            k = 0;
            do begin @(negedge clk); k++; end while (!if8.done && k < 40);
            chk($sformatf("held_period%0d", r), k, 5);
            chk($sformatf("held_res%0d", r), {if8.Cout, if8.S}, 9'h0FF);
        end
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk("held_release_idle", {if8.done, if8.ready}, 2'b01);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        drive(0, 1'b1, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_S", 32'(if8.S), 0);
        chk("abort_rdy", {if8.done, if8.ready}, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 32'(if8.done), 0);
        op_check("add_03_04", 0, 8'h03, 8'h04, 1'b0);
        chk("add_03_04_S", 32'(if8.S), 32'h07);

        for (int r = 0; r < 40; r++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            op_check($sformatf("rnd%0d_%h_%h_%0d", r, ra, rb, rc), 0, ra, rb, rc);
        end

        for (int inst = 1; inst < 3; inst++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int c = 0; c < 2; c++) begin
                        do_op(inst, 8'(a), 8'(b), 1'(c), res, lat, busy);
                        chk($sformatf("ex%0d_%0d_%0d_%0d", inst, a, b, c), 32'(res),
                            32'(ref_sum(4, a, b, c)));
                        chk($sformatf("ex%0d_lat", inst), lat, n_of(inst) + 1);
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder that computes S = A + B + Cin over WIDTH bits. It processes DIGIT bits per clock, least-significant digit first, and signals completion with a one-cycle done pulse. It is the sequential, width-generalised successor to the single-bit half/full adder cells, and it is the reusable multi-cycle addition datapath for the arithmetic blocks that follow.

## Interface
- WIDTH, 32, operand/result width in bits; must be a positive multiple of DIGIT
- DIGIT, 4, bits consumed per cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new addition; accepted only while ready=1
- ready  output  1  high in IDLE and DONE (start may be accepted)
- A  input  WIDTH  operand A, sampled on accepting edge only
- B  input  WIDTH  operand B, sampled on accepting edge only
- Cin  input  1  carry in, sampled on accepting edge only
- S  output  WIDTH  sum register
- Cout  output  1  unsigned carry out of bit WIDTH-1
- Ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
- done  output  1  one-cycle pulse: S/Cout/Ovf valid

## Operation
- N = WIDTH/DIGIT digit steps per addition.
- States:
  - IDLE → RUN on start.
  - RUN stays RUN while the digit counter < N-1; RUN → DONE when the last digit is consumed.
  - DONE → RUN on start, else DONE → IDLE.
- On acceptance:
  - latch A, B into shift registers;
  - load the carry register with Cin;
  - clear the counter.
- Each RUN edge:
  - add the low DIGIT bits of the A and B shift registers plus the carry register;
  - shift the sum digit into the MSB end of the S register; shift A and B right by DIGIT;
  - update the carry register; increment the counter.
- After N steps S holds the full sum, aligned.
- On the final digit, Cout takes the digit carry out and Ovf takes (carry into bit WIDTH-1) XOR (carry out). When DIGIT=1, the carry into the MSB is the carry register value.
- S, Cout and Ovf hold their values from DONE until the next operation's final digit. S is not cleared on start; intermediate S contents during RUN are don't-care to consumers.
- start while in RUN is ignored: no effect on operands or state.
- A, B and Cin are ignored except on the accepting edge.

## Timing
- Reset values: state IDLE, S=0, Cout=0, Ovf=0, done=0, counter=0, ready=1.
- Reset acts immediately, without waiting for a clock edge, and aborts any operation in progress.
- Latency: start accepted at edge 0. Digits are consumed on edges 1..N. done=1 during the cycle after edge N, and S/Cout/Ovf are valid in that same cycle.
- Throughput: start held high continuously gives one result every N+1 cycles. Each start is accepted in DONE, concurrently with that cycle's done pulse.
- done is exactly one cycle wide and never asserts without a preceding accepted start.
- ready is a combinational decode of state: 1 in IDLE and DONE, 0 in RUN.
- Counter width: clog2(N) bits, minimum 1. No wrap beyond N-1.

## Structure
- Package adder_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - a function or localparam for N and the counter width.
- Sub-module digit_adder: a DIGIT-bit ripple chain of full-adder cells.
  - Ports: a, b, cin, sum, cout, c_msb (carry into its top bit).
  - Instantiated once; it is purely combinational.
- The top level contains the FSM, counter, operand shift registers and the result register.

## Test plan
- Reset, WIDTH=8 DIGIT=2: assert reset mid-cycle. Immediately S=8'h00, Cout=0, Ovf=0, done=0, ready=1.
- A=8'h0F, B=8'h01, Cin=0, start at edge 0: ready=0 on edges 1–4; done=1 after edge 4 with S=8'h10, Cout=0, Ovf=0.
- A=8'hFF, B=8'h01, Cin=0 → S=8'h00, Cout=1, Ovf=0. Then A=8'h7F, B=8'h00, Cin=1 → S=8'h80, Cout=0, Ovf=1.
- Pulse start with A=8'h01, B=8'h01 during RUN of an op with A=8'h22, B=8'h11 → ignored; result S=8'h33. Then hold start high with A=8'hAA, B=8'h55 → accepted in DONE; next done shows S=8'hFF, Cout=0, and exactly N+1 cycles between done pulses.
- Reset asserted at RUN step 2 → state IDLE, S=0 at once. A fresh start with A=8'h03, B=8'h04 then yields S=8'h07.
- WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4: exhaustive over A, B, Cin (512 cases). {Cout,S} must equal A+B+Cin, and Ovf must match the signed-sum reference.
